// File: rtl/crc16_pkg.sv
// Shared CRC-16/CCITT-FALSE constants and the single-byte update used by the unrolled chain.
package crc16_pkg;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  // One byte, MSB-first, no reflection.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] d);
    logic [15:0] c;
    c = crc ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ({c[14:0], 1'b0} ^ CRC16_POLY) : {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/crc16_byte_step.sv
// Combinational one-byte CRC-16 update; chained once per payload byte by crc16.
module crc16_byte_step
  import crc16_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  assign crc_o = crc16_byte(crc_i, data_i);

endmodule

// File: rtl/crc16.sv
// Single-cycle CRC-16 over a parallel packet: all payload bytes are hashed in one unrolled chain,
// the result is compared with the trailing big-endian CRC, and both are registered.
module crc16
  import crc16_pkg::*;
#(
  parameter int unsigned PACKAGE_SIZE = 16,
  parameter int unsigned STREAM_SIZE  = 128
) (
  input  logic                   iClk,
  input  logic                   iRst_n,
  input  logic                   iDataValid,
  input  logic [STREAM_SIZE-1:0] iData,
  output logic                   oSuccess,
  output logic                   oFinish,
  output logic [15:0]            oCrc
);

  localparam int unsigned NumBytes = PACKAGE_SIZE - 2;

  logic [15:0] chain [NumBytes+1];
  logic [15:0] crc_calc;

  assign chain[0] = CRC16_INIT;

  // Byte 0 sits in the top byte of iData.
  for (genvar g = 0; g < NumBytes; g++) begin : gen_step
    crc16_byte_step u_step (
      .crc_i  (chain[g]),
      .data_i (iData[STREAM_SIZE-1-8*g -: 8]),
      .crc_o  (chain[g+1])
    );
  end

  assign crc_calc = chain[NumBytes];

  logic [15:0] crc_d, crc_q;
  logic        success_d, success_q;
  logic        finish_d, finish_q;

  always_comb begin
    crc_d     = crc_q;
    success_d = success_q;
    finish_d  = iDataValid;
    if (iDataValid) begin
      crc_d     = crc_calc;
      success_d = (crc_calc == iData[15:0]);
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      crc_q     <= 16'h0000;
      success_q <= 1'b0;
      finish_q  <= 1'b0;
    end else begin
      crc_q     <= crc_d;
      success_q <= success_d;
      finish_q  <= finish_d;
    end
  end

  assign oCrc     = crc_q;
  assign oSuccess = success_q;
  assign oFinish  = finish_q;

endmodule

// File: tb/tb_crc16.sv
// Directed bench for crc16: an RX (9-byte) and a TX (16-byte) instance against a bit-serial model.
module tb_crc16;

  logic Clk_50M = 1'b0;
  always #10 Clk_50M = ~Clk_50M;

  logic        rst_n;
  logic        rx_valid, tx_valid;
  logic [71:0] rx_data;
  logic [127:0] tx_data;
  logic        rx_success, rx_finish, tx_success, tx_finish;
  logic [15:0] rx_crc, tx_crc;

  crc16 #(.PACKAGE_SIZE(9), .STREAM_SIZE(72)) u_rx (
    .iClk       (Clk_50M),
    .iRst_n     (rst_n),
    .iDataValid (rx_valid),
    .iData      (rx_data),
    .oSuccess   (rx_success),
    .oFinish    (rx_finish),
    .oCrc       (rx_crc)
  );

  crc16 #(.PACKAGE_SIZE(16), .STREAM_SIZE(128)) u_tx (
    .iClk       (Clk_50M),
    .iRst_n     (rst_n),
    .iDataValid (tx_valid),
    .iData      (tx_data),
    .oSuccess   (tx_success),
    .oFinish    (tx_finish),
    .oCrc       (tx_crc)
  );

  int checks = 0;
  int errors = 0;

  // Bit-serial reference; payload right-aligned, first byte most significant.
  function automatic logic [15:0] model_crc(input logic [127:0] payload, input int nbytes);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < nbytes; i++) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[15] ^ payload[8*(nbytes-1-i)+b];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction

  function automatic logic [15:0] rx_model(input logic [55:0] p);
    return model_crc({72'h0, p}, 7);
  endfunction

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  typedef struct {
    logic        valid;
    logic [71:0] data;
    logic        exp_finish;
    logic [15:0] exp_crc;
    logic        exp_success;
  } vec_t;

  vec_t        vecs[10];
  logic [55:0] p1, p2, p3, p4;
  logic [15:0] m1, m2, m3, m4, mtx;

  initial begin
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    tx_valid = 1'b0;
    rx_data  = '0;
    tx_data  = '0;

    p1 = 56'hFFFA8080800000;
    p2 = 56'hFFFA171717E000;
    p3 = 56'hFFFA1B9022E0FF;
    p4 = 56'h01020304050607;
    m1 = rx_model(p1);
    m2 = rx_model(p2);
    m3 = rx_model(p3);
    m4 = rx_model(p4);

    // Matching CRC, then mismatch; then alternating valid/idle with garbage while idle.
    vecs[0] = '{1'b1, {p1, m1},          1'b1, m1, 1'b1};
    vecs[1] = '{1'b1, {p1, 16'h1234},    1'b1, m1, (m1 == 16'h1234)};
    vecs[2] = '{1'b1, {p2, m2},          1'b1, m2, 1'b1};
    vecs[3] = '{1'b0, 72'hDEADBEEF_0123456789, 1'b0, m2, 1'b1};
    vecs[4] = '{1'b1, {p2, m2 + 16'd1},  1'b1, m2, 1'b0};
    vecs[5] = '{1'b0, {p3, m3},          1'b0, m2, 1'b0};
    vecs[6] = '{1'b1, {p3, m3},          1'b1, m3, 1'b1};
    vecs[7] = '{1'b0, {p1, m1},          1'b0, m3, 1'b1};
    vecs[8] = '{1'b1, {p3, m3 + 16'd1},  1'b1, m3, 1'b0};
    vecs[9] = '{1'b0, 72'hFFFFFFFFFFFFFFFFFF, 1'b0, m3, 1'b0};

    // Reset state
    @(posedge Clk_50M); #1;
    chk16("rst_rx_crc", rx_crc, 16'h0000);
    chk1("rst_rx_success", rx_success, 1'b0);
    chk1("rst_rx_finish", rx_finish, 1'b0);
    chk16("rst_tx_crc", tx_crc, 16'h0000);
    chk1("rst_tx_finish", tx_finish, 1'b0);

    // Release with no valid data: nothing changes
    rst_n = 1'b1;
    repeat (2) @(posedge Clk_50M);
    #1;
    chk16("rel_rx_crc", rx_crc, 16'h0000);
    chk1("rel_rx_finish", rx_finish, 1'b0);
    chk1("rel_tx_success", tx_success, 1'b0);

    for (int i = 0; i < 10; i++) begin
      rx_valid = vecs[i].valid;
      rx_data  = vecs[i].data;
      @(posedge Clk_50M); #1;
      chk1($sformatf("vec%0d_finish", i), rx_finish, vecs[i].exp_finish);
      chk16($sformatf("vec%0d_crc", i), rx_crc, vecs[i].exp_crc);
      chk1($sformatf("vec%0d_success", i), rx_success, vecs[i].exp_success);
    end
    rx_valid = 1'b0;

    // TX: FF FA followed by twelve zero bytes, trailing CRC field zero
    mtx      = model_crc({8'hFF, 8'hFA, 112'h0} >> 16, 14);
    tx_data  = {8'hFF, 8'hFA, 112'h0};
    tx_valid = 1'b1;
    @(posedge Clk_50M); #1;
    chk1("tx0_finish", tx_finish, 1'b1);
    chk16("tx0_crc", tx_crc, mtx);
    chk1("tx0_success", tx_success, (mtx == 16'h0000));
    tx_data[15:0] = mtx;
    @(posedge Clk_50M); #1;
    chk16("tx1_crc", tx_crc, mtx);
    chk1("tx1_success", tx_success, 1'b1);
    chk1("rx_idle_finish", rx_finish, 1'b0);
    tx_valid = 1'b0;
    @(posedge Clk_50M); #1;
    chk1("tx2_finish", tx_finish, 1'b0);
    chk16("tx2_crc_hold", tx_crc, mtx);

    // Back-to-back valid packets
    rx_valid = 1'b1;
    rx_data  = {p4, m4};
    @(posedge Clk_50M); #1;
    chk1("b2b0_finish", rx_finish, 1'b1);
    chk16("b2b0_crc", rx_crc, m4);
    chk1("b2b0_success", rx_success, 1'b1);
    rx_data = {p3, m3 ^ 16'h8000};
    @(posedge Clk_50M); #1;
    chk1("b2b1_finish", rx_finish, 1'b1);
    chk16("b2b1_crc", rx_crc, m3);
    chk1("b2b1_success", rx_success, 1'b0);
    rx_data = {p1, m1};
    @(posedge Clk_50M); #1;
    chk1("b2b2_finish", rx_finish, 1'b1);
    chk16("b2b2_crc", rx_crc, m1);
    chk1("b2b2_success", rx_success, 1'b1);

    // Async reset right after a valid result, clearing before the next edge
    #4 rst_n = 1'b0;
    #1;
    chk1("arst_finish", rx_finish, 1'b0);
    chk1("arst_success", rx_success, 1'b0);
    chk16("arst_crc", rx_crc, 16'h0000);
    chk16("arst_tx_crc", tx_crc, 16'h0000);
    // Valid packet while reset is still low is ignored
    @(posedge Clk_50M); #1;
    chk1("rstlow_finish", rx_finish, 1'b0);
    chk16("rstlow_crc", rx_crc, 16'h0000);
    rst_n = 1'b1;
    @(posedge Clk_50M); #1;
    chk1("post_finish", rx_finish, 1'b1);
    chk16("post_crc", rx_crc, m1);
    chk1("post_success", rx_success, 1'b1);
    rx_valid = 1'b0;
    @(posedge Clk_50M); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
